// File: rtl/cavlc_enc_arbiter.sv
// Round-robin sharing of one CAVLC block encoder between the luma (src0) and chroma (src1) feeders.
// A single-entry result buffer holds the source-tagged result, and a watchdog bounds the wait for the encoder.
module cavlc_enc_arbiter #(
  parameter int CODE_W  = 128,
  parameter int BIT_W   = 7,
  parameter int XY_W    = 10,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  output logic              grant_sel,
  output logic              enc_cnt_valid,
  input  logic              enc_ready,
  input  logic              enc_valid,
  input  logic [CODE_W-1:0] enc_code,
  input  logic [BIT_W-1:0]  enc_bit,
  input  logic [XY_W-1:0]   enc_x,
  input  logic [XY_W-1:0]   enc_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CODE_W-1:0] res_code,
  output logic [BIT_W-1:0]  res_bit,
  output logic [XY_W-1:0]   res_x,
  output logic [XY_W-1:0]   res_y,
  output logic              res_src,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             sel_valid;
  logic             handshake;

  // The grant is locked in ISSUE: only the selected source's request is forwarded.
  assign sel_valid     = req_valid[grant_sel];
  assign enc_cnt_valid = (state == ISSUE) & sel_valid;
  assign handshake     = enc_cnt_valid & enc_ready;
  assign req_ready[0]  = handshake & ~grant_sel;
  assign req_ready[1]  = handshake & grant_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_sel   <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_code    <= '0;
      res_bit     <= '0;
      res_x       <= '0;
      res_y       <= '0;
      res_src     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_sel <= (&req_valid) ? ~last_grant : req_valid[1];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            last_grant <= grant_sel;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // A result arriving on the expiry cycle takes priority over the watchdog.
          if (enc_valid) begin
            res_code  <= enc_code;
            res_bit   <= enc_bit;
            res_x     <= enc_x;
            res_y     <= enc_y;
            res_src   <= grant_sel;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else if (cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cavlc_enc_arbiter.md
Name: cavlc_enc_arbiter

Overview:
Shares one CAVLC 4x4-block encoder between two requesters: src0 = luma block feeder, src1 = chroma block feeder. Arbitrates round-robin and drives the encoder's count-valid strobe. Drives a select line for the external payload mux (counts, lists, topleft). Captures the one-cycle encoder result into a single-entry buffer, tags it with its source, and adds a watchdog on the encoder response.

Parameters:
CODE_W, 128, width of encoded bitstream word
BIT_W, 7, width of bit-length field
XY_W, 10, width of topleft x/y
TIMEOUT, 32, max cycles in BUSY waiting for enc_valid (>=20)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  2  per-source block ready to encode; held until req_ready
req_ready  out  2  per-source accept strobe
grant_sel  out  1  payload mux select (0=src0, 1=src1)
enc_cnt_valid  out  1  to encoder count-valid input
enc_ready  in  1  encoder idle/ready
enc_valid  in  1  encoder result valid (single-cycle pulse)
enc_code  in  CODE_W  encoder bitstream
enc_bit  in  BIT_W  encoder bit count
enc_x  in  XY_W  encoder registered topleft x
enc_y  in  XY_W  encoder registered topleft y
res_valid  out  1  result buffer full
res_ready  in  1  downstream accept
res_code  out  CODE_W  buffered bitstream
res_bit  out  BIT_W  buffered bit count
res_x  out  XY_W  buffered topleft x
res_y  out  XY_W  buffered topleft y
res_src  out  1  source tag of buffered result
err_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async assert): state=IDLE, all outputs 0, last_grant=1 (src0 wins first tie), timeout counter=0, buffer cleared.
- States: IDLE, ISSUE, BUSY, HOLD.
- IDLE: if any req_valid, register grant_sel and go to ISSUE.
  - Both valid: pick source != last_grant.
  - One valid: pick that source.
  - No request: stay.
- ISSUE: enc_cnt_valid = req_valid[grant_sel]; req_ready[grant_sel] = enc_ready & req_valid[grant_sel]; other req_ready=0.
  - Handshake (both high): last_grant<=grant_sel, counter<=0, go to BUSY.
  - Otherwise stay. Grant is locked until handshake; the other source cannot preempt.
- BUSY: enc_cnt_valid=0; counter increments each cycle.
  - enc_valid=1: capture enc_code/bit/x/y into res_*, res_src<=grant_sel, go to HOLD.
  - Else if counter==TIMEOUT-1: err_timeout=1 for one cycle, go to IDLE, no result.
  - enc_valid on the expiry cycle: valid wins; result captured, no error.
- HOLD: res_valid=1, res_* stable.
  - res_ready=1: res_valid drops next cycle, go to IDLE.
  - No issue while HOLD (single buffer; encoder result is unbackpressurable).
- enc_valid outside BUSY is ignored.
- grant_sel remains stable from IDLE exit through HOLD.
- res_* hold their last values after consumption; only res_valid qualifies them.
- Latency: req_valid rise (idle, enc_ready=1) -> req_ready 1 cycle later. enc_valid -> res_valid next cycle. Min spacing between grants = encoder latency + 3 cycles.
- Counter width = clog2(TIMEOUT)+1; no wrap in BUSY.
- Reset mid-operation: immediate return to reset values; in-flight block dropped, no err_timeout.

Test Plan:
- Single src0 req, enc_ready=1, encoder model asserts enc_valid 18 cycles after accept with code=128'hA5..., bit=37, x=16, y=8 -> req_ready[0] single pulse; res_valid next cycle with res_code/bit/x/y matching, res_src=0; enc_cnt_valid low after accept.
- Both sources valid continuously, res_ready=1 -> grants alternate 0,1,0,1; first grant src0; res_src sequence 0,1,0,1.
- res_ready held low 10 cycles after result -> res_valid and res_* stable; enc_cnt_valid=0 and req_ready=0 throughout; release -> next grant proceeds.
- Encoder never responds -> err_timeout pulses exactly 32 cycles after accept; res_valid stays 0; state returns to IDLE; pending src1 granted next.
- enc_valid on cycle TIMEOUT-1 in BUSY -> result captured, err_timeout stays 0.
- rst asserted asynchronously mid-BUSY -> all outputs 0 without clock edge; after release, pending src0 and src1 -> src0 granted first.
